// File: rtl/insn_fetch.sv
// -----------------------------------------------------------------------------
// insn_fetch: instruction fetch unit in front of the control decoder.
//
// Generates the PC and drives a synchronous instruction ROM. Fetched words go
// into a small FIFO whose head is presented to the decoder over a valid/ready
// handshake. A redirect (or reset) reloads the PC and flushes both the FIFO and
// any fetch still in flight.
//
// Build option:
//   FETCH_BUF_EN defined   -> 2-entry queue, one instruction per cycle.
//   FETCH_BUF_EN undefined -> 1-entry output register, at most one
//                             instruction every two cycles.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high; flushes and loads RESET_PC
//   imem_addr    out  ROM word address (the current PC)
//   imem_q       in   ROM data for the address presented before the last edge
//   redirect     in   load redirect_pc and flush all pending fetches
//   redirect_pc  in   redirect target
//   dec_ready    in   decoder accepts the head instruction this cycle
//   insn_valid   out  insn/insn_pc/opcode/alu_op carry a valid instruction
//   insn         out  instruction word (0 when not valid)
//   insn_pc      out  word address of insn (0 when not valid)
//   opcode       out  insn[31:27]
//   alu_op       out  insn[6:2] for opcode 0, otherwise 0
// -----------------------------------------------------------------------------
module insn_fetch #(
    parameter int unsigned       ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_ready,
    output logic              insn_valid,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic [4:0]        opcode,
    output logic [4:0]        alu_op
);

`ifdef FETCH_BUF_EN
    localparam int unsigned Depth = 2;
`else
    localparam int unsigned Depth = 1;
`endif

    // StFlush: edge with reset/redirect just happened; StFill: queue empty;
    // StRun: queue holds at least one instruction.
    typedef enum logic [1:0] {StFlush, StFill, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]        occ_q, occ_d;
    // Two physical slots; slot 0 is always the head. The unbuffered build
    // never writes slot 1.
    logic [31:0]       buf_insn_q [2];
    logic [31:0]       buf_insn_d [2];
    logic [ADDR_W-1:0] buf_pc_q   [2];
    logic [ADDR_W-1:0] buf_pc_d   [2];

    logic              pop;
    logic              issue;
    logic              wr_idx;
    logic [2:0]        slots_used;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        occ_d         = occ_q;
        buf_insn_d    = buf_insn_q;
        buf_pc_d      = buf_pc_q;
        issue         = 1'b0;

        pop        = (occ_q != 2'd0) && dec_ready;
        // Slot for the returning fetch after the head leaves: occ - pop,
        // which is always 0 or 1 when a fetch is in flight.
        wr_idx     = occ_q[0] ^ pop;
        // Counting the departing head lets a released stall refill with no bubble.
        slots_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

        if (redirect) begin
            // Redirect wins over a simultaneous handshake; the in-flight word is dropped.
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            occ_d      = 2'd0;
            state_d    = StFlush;
        end else begin
            issue = slots_used < 3'(Depth);

            if (pop) begin
                buf_insn_d[0] = buf_insn_q[1];
                buf_pc_d[0]   = buf_pc_q[1];
            end
            if (inflight_q) begin
                buf_insn_d[wr_idx] = imem_q;
                buf_pc_d[wr_idx]   = inflight_pc_q;
            end
            occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + ADDR_W'(1);
            end

            state_d = (occ_d != 2'd0) ? StRun : StFill;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StFlush;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            occ_q         <= 2'd0;
            buf_insn_q[0] <= '0;
            buf_insn_q[1] <= '0;
            buf_pc_q[0]   <= '0;
            buf_pc_q[1]   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            occ_q         <= occ_d;
            buf_insn_q[0] <= buf_insn_d[0];
            buf_insn_q[1] <= buf_insn_d[1];
            buf_pc_q[0]   <= buf_pc_d[0];
            buf_pc_q[1]   <= buf_pc_d[1];
        end
    end

    assign insn_valid = (state_q == StRun);

    // Outputs read as zero whenever nothing valid is presented.
    always_comb begin
        imem_addr = pc_q;
        insn      = '0;
        insn_pc   = '0;
        opcode    = '0;
        alu_op    = '0;
        if (insn_valid) begin
            insn    = buf_insn_q[0];
            insn_pc = buf_pc_q[0];
            opcode  = buf_insn_q[0][31:27];
            if (buf_insn_q[0][31:27] == 5'd0) begin
                alu_op = buf_insn_q[0][6:2];
            end
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
// -----------------------------------------------------------------------------
// tb_insn_fetch: self-checking bench for insn_fetch.
//
// A queue-based reference model tracks which PCs must be presented to the
// decoder; a compare process checks every DUT output against it on each
// falling edge. Directed scenarios add literal expectations that pin the
// model: reset release, R-type/non-R-type alu_op, stall and release, redirects
// (in flight, full queue, back-to-back), PC wrap, and reset while stalled.
// Works for both builds (FETCH_BUF_EN defined or not).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_insn_fetch;

    localparam int unsigned AW = 12;
    localparam logic [AW-1:0] RST_PC = 12'h000;
`ifdef FETCH_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          dec_ready = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic          insn_valid;
    logic [31:0]   insn;
    logic [AW-1:0] insn_pc;
    logic [4:0]    opcode;
    logic [4:0]    alu_op;

    logic [31:0]   rom [0:(1<<AW)-1];
    logic [31:0]   rom_w;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [AW-1:0] mq[$];
    bit            m_infl = 1'b0;
    logic [AW-1:0] m_infl_pc = '0;
    logic [AW-1:0] m_pc = '0;
    bit            m_ok = 1'b0;
    int            m_sz;
    bit            m_pop;
    bit            m_issue;
    logic [AW-1:0] ep;
    logic [31:0]   ew;

    logic [AW-1:0] seen [0:7];
    int            seen_cnt;

    insn_fetch #(
        .ADDR_W  (AW),
        .RESET_PC(RST_PC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_q     (imem_q),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dec_ready  (dec_ready),
        .insn_valid (insn_valid),
        .insn       (insn),
        .insn_pc    (insn_pc),
        .opcode     (opcode),
        .alu_op     (alu_op)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data for the sampled address appears after the edge.
    always @(posedge clock) imem_q <= rom[imem_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    function automatic logic [4:0] exp_alu(input logic [31:0] w);
        return (w[31:27] == 5'd0) ? w[6:2] : 5'd0;
    endfunction

    // Reference model: the fetch stream as a list of addresses waiting for
    // the decoder plus at most one outstanding ROM read.
    always @(posedge clock) begin
        m_sz  = mq.size();
        m_pop = (m_sz != 0) && dec_ready;
        if (reset || redirect) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = reset ? RST_PC : redirect_pc;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            m_issue = (m_sz + int'(m_infl) - int'(m_pop)) < CAP;
            if (m_pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            m_infl = m_issue;
            if (m_issue) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 1'b1;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clock) begin
        if (m_ok) begin
            check("cmp_valid", {31'd0, insn_valid}, {31'd0, mq.size() != 0});
            check("cmp_imem_addr", 32'(imem_addr), 32'(m_pc));
            if (mq.size() != 0) begin
                ep = mq[0];
                ew = rom[ep];
                check("cmp_insn_pc", 32'(insn_pc), 32'(ep));
                check("cmp_insn", insn, ew);
                check("cmp_opcode", 32'(opcode), 32'(ew[31:27]));
                check("cmp_alu_op", 32'(alu_op), 32'(exp_alu(ew)));
            end else begin
                check("cmp_idle_insn", insn, 32'd0);
                check("cmp_idle_pc", 32'(insn_pc), 32'd0);
                check("cmp_idle_fields", {22'd0, opcode, alu_op}, 32'd0);
            end
        end
    end

    // Record up to three transferred PCs within a bounded cycle budget.
    task automatic collect3();
        seen_cnt = 0;
        for (int i = 0; i < 8; i++) seen[i] = 'x;
        for (int i = 0; i < 20 && seen_cnt < 3; i++) begin
            @(negedge clock);
            if (insn_valid && dec_ready) begin
                seen[seen_cnt] = insn_pc;
                seen_cnt++;
            end
        end
        check("collect_count", 32'(seen_cnt), 32'd3);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            rom_w = (i * 32'h9E3779B1) ^ (i << 7);
            if (i % 3 == 0) rom_w[31:27] = 5'd0;
            rom[i] = rom_w;
        end
        rom[0] = 32'h2800_0000;  // opcode 00101
        rom[1] = 32'h0000_0008;  // opcode 0, bits[6:2] = 00010
        rom[2] = 32'h2800_000C;  // opcode 00101, bits[6:2] = 00011

        // --- Reset release, continuous dec_ready ---
        reset     = 1'b1;
        dec_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_valid", {31'd0, insn_valid}, 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_insn", insn, 32'd0);
        check("rst_fields", {10'd0, 12'(insn_pc), opcode, alu_op}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("fill_valid", {31'd0, insn_valid}, 32'd0);
        check("fill_imem_addr", 32'(imem_addr), 32'd1);
        @(negedge clock);
        check("first_valid", {31'd0, insn_valid}, 32'd1);
        check("first_insn", insn, 32'h2800_0000);
        check("first_opcode", 32'(opcode), 32'h05);
        check("first_alu_op", 32'(alu_op), 32'd0);
        check("first_pc", 32'(insn_pc), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            repeat (CAP == 2 ? 1 : 2) @(negedge clock);
            check("seq_valid", {31'd0, insn_valid}, 32'd1);
            check("seq_pc", 32'(insn_pc), 32'(k));
            if (k == 1) check("rtype_alu_op", 32'(alu_op), 32'h02);
            if (k == 2) begin
                check("itype_opcode", 32'(opcode), 32'h05);
                check("itype_alu_op", 32'(alu_op), 32'd0);
            end
        end

        // --- Stall for five cycles after first valid, then release ---
        dec_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("stall_fill_valid", {31'd0, insn_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_valid", {31'd0, insn_valid}, 32'd1);
            check("stall_pc", 32'(insn_pc), 32'd0);
            check("stall_imem_addr", 32'(imem_addr), 32'(CAP));
        end
        dec_ready = 1'b1;
        @(negedge clock);
        check("release_valid", {31'd0, insn_valid}, (CAP == 2) ? 32'd1 : 32'd0);
        repeat (3) @(negedge clock);

        // --- Redirect with a fetch in flight ---
        redirect    = 1'b1;
        redirect_pc = 12'h100;
        @(negedge clock);
        redirect = 1'b0;
        check("redir_valid0", {31'd0, insn_valid}, 32'd0);
        check("redir_addr0", 32'(imem_addr), 32'h100);
        @(negedge clock);
        check("redir_valid1", {31'd0, insn_valid}, 32'd0);
        check("redir_addr1", 32'(imem_addr), 32'h101);
        @(negedge clock);
        check("redir_valid2", {31'd0, insn_valid}, 32'd1);
        check("redir_pc2", 32'(insn_pc), 32'h100);

        // --- Redirect while the queue is full and a handshake coincides ---
        dec_ready = 1'b0;
        repeat (4) @(negedge clock);
        redirect    = 1'b1;
        redirect_pc = 12'h200;
        dec_ready   = 1'b1;
        @(negedge clock);
        redirect = 1'b0;
        check("full_redir_valid", {31'd0, insn_valid}, 32'd0);
        repeat (4) @(negedge clock);

        // --- Back-to-back redirects ---
        redirect    = 1'b1;
        redirect_pc = 12'h300;
        @(negedge clock);
        redirect_pc = 12'h340;
        @(negedge clock);
        redirect = 1'b0;
        check("b2b_addr", 32'(imem_addr), 32'h340);
        repeat (2) @(negedge clock);
        check("b2b_valid", {31'd0, insn_valid}, 32'd1);
        check("b2b_pc", 32'(insn_pc), 32'h340);

        // --- PC wrap ---
        redirect    = 1'b1;
        redirect_pc = 12'hFFE;
        @(negedge clock);
        redirect = 1'b0;
        collect3();
        check("wrap_pc0", 32'(seen[0]), 32'hFFE);
        check("wrap_pc1", 32'(seen[1]), 32'hFFF);
        check("wrap_pc2", 32'(seen[2]), 32'h000);

        // --- Reset while stalled with the queue full ---
        dec_ready = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_valid", {31'd0, insn_valid}, 32'd0);
        check("midrst_insn", insn, 32'd0);
        check("midrst_fields", {10'd0, 12'(insn_pc), opcode, alu_op}, 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'(RST_PC));
        dec_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("restart_valid", {31'd0, insn_valid}, 32'd1);
        check("restart_pc", 32'(insn_pc), 32'(RST_PC));
        repeat (6) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
